ahb_resp_mux_pipe: RTL
======================

AHB_RESP_MUX_PIPE -- requirements
Module: ahb_resp_mux_pipe

Interface
REQ-001 Parameter CHANNEL_NUM, default 2, number of slave channels (range 1..16).
REQ-002 Parameter DATA_W, default 32, HRDATA width.
REQ-003 Parameter ERRCNT_W, default 8, width of the unmapped-access error counter.
REQ-004 HCLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 addr_sel  input  CHANNEL_NUM  address-phase decoder select, expected one-hot or zero.
REQ-007 htrans  input  2  address-phase HTRANS: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 hready  input  1  bus-wide HREADY fed back from this block's hreadyout.
REQ-009 slv_hrdata  input  CHANNEL_NUM x DATA_W  per-slave read data.
REQ-010 slv_hresp  input  CHANNEL_NUM  per-slave HRESP (1=ERROR).
REQ-011 slv_hreadyout  input  CHANNEL_NUM  per-slave HREADYOUT.
REQ-012 hrdata  output  DATA_W  muxed read data to master.
REQ-013 hresp  output  1  muxed response.
REQ-014 hreadyout  output  1  muxed ready.
REQ-015 sel_err  output  1  sticky flag, set on any captured non-one-hot, non-zero addr_sel.
REQ-016 err_cnt  output  ERRCNT_W  saturating count of default-slave ERROR responses.

Function
REQ-017 Data-phase select register sel_q shall load addr_sel on an HCLK edge with hready=1 and hold otherwise.
REQ-018 With sel_q one-hot bit i, outputs shall equal slv_hrdata[i], slv_hresp[i], slv_hreadyout[i], combinationally, with zero added latency.
REQ-019 Captured zero or non-one-hot addr_sel with htrans NONSEQ/SEQ shall start the default slave; with IDLE/BUSY, the data phase shall be an OKAY zero-wait response (hreadyout=1, hresp=0, hrdata=0).
REQ-020 The default-slave FSM shall have states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-021 DS_IDLE->DS_ERR1 on the capture in REQ-019; DS_ERR1 drives hreadyout=0, hresp=1.
REQ-022 DS_ERR1->DS_ERR2 unconditionally; DS_ERR2 drives hreadyout=1, hresp=1.
REQ-023 From DS_ERR2: another unmapped active capture ->DS_ERR1, else ->DS_IDLE.
REQ-024 While the FSM is not in DS_IDLE, slave inputs shall be ignored and hrdata=0.
REQ-025 err_cnt shall increment by 1 on each DS_ERR1 entry and saturate at all-ones.
REQ-026 sel_err shall be set on capture of an addr_sel with two or more bits set, and cleared only by reset.
REQ-027 Non-one-hot capture shall be treated as unmapped per REQ-019; no slave is routed.
REQ-028 Changes of addr_sel or htrans while hready=0 shall not affect sel_q or FSM state.

Reset
REQ-029 On HRESETn=0: sel_q=0, FSM=DS_IDLE, err_cnt=0, sel_err=0; outputs hreadyout=1, hresp=0, hrdata=0, effective immediately and asynchronously.
REQ-030 Reset asserted in DS_ERR1 or DS_ERR2 shall abort the error response; first post-reset data phase is OKAY zero-wait.

Structure
REQ-031 The HTRANS encoding typedef, the HRESP OKAY/ERROR constants and the default-slave state enum shall live in AHB_package.
REQ-032 The default slave (REQ-020..REQ-025) shall be one sub-module, ahb_default_slave; select register and mux remain in the top.

Verification
REQ-033 CHANNEL_NUM=2; NONSEQ with addr_sel=2'b10, slave1 hrdata=0xCAFE0001 and hreadyout=1 -> next cycle hrdata=0xCAFE0001, hresp=0.
REQ-034 Slave1 holds hreadyout=0 for 3 cycles while the master changes addr_sel to 2'b01 -> sel_q stays 2'b10 for those 3 cycles; slave0 is routed after hready=1.
REQ-035 NONSEQ with addr_sel=0 -> cycle+1: hreadyout=0, hresp=1; cycle+2: hreadyout=1, hresp=1; err_cnt=1.
REQ-036 addr_sel=2'b11 with SEQ -> sel_err=1, two-cycle ERROR, err_cnt increments; sel_err remains 1 after 10 clean transfers.
REQ-037 Back-to-back unmapped NONSEQ captured in DS_ERR2 -> DS_ERR2->DS_ERR1 with no DS_IDLE cycle; with ERRCNT_W=2, five errors -> err_cnt=3.
REQ-038 HRESETn pulsed low during DS_ERR1 -> hreadyout=1, hresp=0 immediately; err_cnt=0; sel_err=0.

Source files
------------

// File: rtl/ahb_resp_mux_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : AHB_package
// Purpose  : Shared AHB types for the response multiplexer: HTRANS encoding,
//            HRESP values and the default-slave state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic c_HRESP_OKAY  = 1'b0;
  localparam logic c_HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ are the only transfer types that need a real response.
  function automatic logic is_active(htrans_e t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_resp_mux_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_resp_mux_pipe_if
// Purpose  : Bus bundle between the address decoder / slaves / master side and
//            the response multiplexer.
// Ports    : slave modport  - seen by the mux (address-phase select, slave
//                             responses in; muxed response and status out)
//            master modport - seen by the surrounding fabric / testbench
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_resp_mux_pipe_if #(
  parameter int CHANNEL_NUM = 2,
  parameter int DATA_W      = 32,
  parameter int ERRCNT_W    = 8
);
  import AHB_package::*;

  logic [CHANNEL_NUM-1:0]             addr_sel;
  htrans_e                            htrans;
  logic                               hready;
  logic [CHANNEL_NUM-1:0][DATA_W-1:0] slv_hrdata;
  logic [CHANNEL_NUM-1:0]             slv_hresp;
  logic [CHANNEL_NUM-1:0]             slv_hreadyout;
  logic [DATA_W-1:0]                  hrdata;
  logic                               hresp;
  logic                               hreadyout;
  logic                               sel_err;
  logic [ERRCNT_W-1:0]                err_cnt;

  modport slave (
    input  addr_sel, htrans, hready, slv_hrdata, slv_hresp, slv_hreadyout,
    output hrdata, hresp, hreadyout, sel_err, err_cnt
  );

  modport master (
    output addr_sel, htrans, hready, slv_hrdata, slv_hresp, slv_hreadyout,
    input  hrdata, hresp, hreadyout, sel_err, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ahb_resp_mux_pipe_default_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_default_slave
// Purpose  : Two-cycle AHB ERROR responder for unmapped active transfers,
//            with a saturating count of error responses issued.
// Ports    : clk, rst_n     - clock, async active-low reset
//            i_start        - unmapped NONSEQ/SEQ captured this edge
//            o_busy         - error response in progress (mux must ignore
//                             slaves and drive zero read data)
//            o_hreadyout    - default-slave HREADYOUT
//            o_hresp        - default-slave HRESP
//            o_err_cnt      - saturating error response counter
// Revision : 1.0 - initial release
// ============================================================================
module ahb_default_slave
  import AHB_package::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                i_start,
  output logic                     o_busy,
  output logic                     o_hreadyout,
  output logic                     o_hresp,
  output logic [ERRCNT_W-1:0]      o_err_cnt
);

  ds_state_e           r_state;
  ds_state_e           w_next;
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DS_IDLE;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Every entry into DS_ERR1 marks one new error response.
      if ((w_next == DS_ERR1) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b0;
    o_hreadyout = 1'b1;
    o_hresp     = c_HRESP_OKAY;
    case (r_state)
      DS_IDLE: begin
        if (i_start) w_next = DS_ERR1;
      end
      DS_ERR1: begin
        o_busy      = 1'b1;
        o_hreadyout = 1'b0;
        o_hresp     = c_HRESP_ERROR;
        w_next      = DS_ERR2;
      end
      DS_ERR2: begin
        o_busy      = 1'b1;
        o_hreadyout = 1'b1;
        o_hresp     = c_HRESP_ERROR;
        // A back-to-back unmapped transfer skips the idle cycle.
        w_next      = i_start ? DS_ERR1 : DS_IDLE;
      end
      default: w_next = DS_IDLE;
    endcase
  end

  assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/ahb_resp_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ahb_resp_mux_pipe
// Purpose  : AHB data-phase response multiplexer. Registers the decoder select
//            at the address phase and routes the selected slave's response
//            with no added latency; unmapped active transfers go to an
//            internal default slave that answers with a two-cycle ERROR.
// Ports    : HCLK, HRESETn  - clock, async active-low reset
//            bus (slave)    - addr_sel/htrans/hready and per-slave responses
//                             in; hrdata/hresp/hreadyout, sel_err, err_cnt out
// Revision : 1.0 - initial release
// ============================================================================
module ahb_resp_mux_pipe
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int DATA_W      = 32,
  parameter int ERRCNT_W    = 8
) (
  input  wire logic            HCLK,
  input  wire logic            HRESETn,
  ahb_resp_mux_pipe_if.slave   bus
);

  logic [CHANNEL_NUM-1:0] r_sel;
  logic                   r_sel_err;

  logic                   w_in_onehot;
  logic                   w_in_multi;
  logic                   w_ds_start;
  logic                   w_sel_onehot;
  logic                   w_ds_busy;
  logic                   w_ds_hreadyout;
  logic                   w_ds_hresp;
  logic [ERRCNT_W-1:0]    w_err_cnt;
  logic [DATA_W-1:0]      w_mux_rdata;
  logic                   w_mux_resp;
  logic                   w_mux_ready;
  logic [DATA_W-1:0]      w_hrdata;
  logic                   w_hresp;
  logic                   w_hreadyout;

  // x & (x-1) clears the lowest set bit: zero result means at most one bit.
  assign w_in_onehot  = (bus.addr_sel != '0) &&
                        ((bus.addr_sel & (bus.addr_sel - CHANNEL_NUM'(1))) == '0);
  assign w_in_multi   = (bus.addr_sel != '0) && !w_in_onehot;
  assign w_sel_onehot = (r_sel != '0) &&
                        ((r_sel & (r_sel - CHANNEL_NUM'(1))) == '0);

  // Zero and multi-hot selects are both unmapped; only active transfers error.
  assign w_ds_start = bus.hready && !w_in_onehot && is_active(bus.htrans);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel     <= '0;
      r_sel_err <= 1'b0;
    end else if (bus.hready) begin
      r_sel <= bus.addr_sel;
      if (w_in_multi) r_sel_err <= 1'b1;
    end
  end

  ahb_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .i_start     (w_ds_start),
    .o_busy      (w_ds_busy),
    .o_hreadyout (w_ds_hreadyout),
    .o_hresp     (w_ds_hresp),
    .o_err_cnt   (w_err_cnt)
  );

  // AND-OR mux; only valid when r_sel is one-hot.
  always_comb begin
    w_mux_rdata = '0;
    w_mux_resp  = 1'b0;
    w_mux_ready = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (r_sel[i]) begin
        w_mux_rdata = w_mux_rdata | bus.slv_hrdata[i];
        w_mux_resp  = w_mux_resp  | bus.slv_hresp[i];
        w_mux_ready = w_mux_ready | bus.slv_hreadyout[i];
      end
    end
  end

  // Default slave owns the bus while responding; an unmapped idle data phase
  // falls through to the zero-wait OKAY branch.
  always_comb begin
    w_hrdata    = '0;
    w_hresp     = c_HRESP_OKAY;
    w_hreadyout = 1'b1;
    if (w_ds_busy) begin
      w_hresp     = w_ds_hresp;
      w_hreadyout = w_ds_hreadyout;
    end else if (w_sel_onehot) begin
      w_hrdata    = w_mux_rdata;
      w_hresp     = w_mux_resp;
      w_hreadyout = w_mux_ready;
    end
  end

  assign bus.hrdata    = w_hrdata;
  assign bus.hresp     = w_hresp;
  assign bus.hreadyout = w_hreadyout;
  assign bus.sel_err   = r_sel_err;
  assign bus.err_cnt   = w_err_cnt;

endmodule
`default_nettype wire
